// File: rtl/bin_threshold_detect_if.sv
// Bundle of frame-control, sample, threshold-ROM and result signals for
// bin_threshold_detect.
//
// Parameters:
//   WN  bin index / ROM address width
//   WL  magnitude and threshold width
//
// Signals (directions as seen by the detector, modport slave):
//   iStart      in   one-cycle frame start request
//   iValid      in   magnitude sample valid
//   oReady      out  detector accepts a sample this cycle
//   iMag        in   unsigned bin magnitude
//   TH_addr     out  threshold ROM address
//   iTH         in   threshold word for TH_addr
//   oValid      out  detection result valid
//   oDet        out  magnitude strictly above threshold
//   oBin        out  bin index of the current result
//   oFrameDone  out  pulse with the result of the last bin
//   oHitCnt     out  detections in the last completed frame
//
// The master modport is the producer/consumer side (sample source, ROM,
// result sink).
interface bin_threshold_detect_if #(
    parameter int WN = 10,
    parameter int WL = 10
);
    logic          iStart;
    logic          iValid;
    logic          oReady;
    logic [WL-1:0] iMag;
    logic [WN-1:0] TH_addr;
    logic [WL-1:0] iTH;
    logic          oValid;
    logic          oDet;
    logic [WN-1:0] oBin;
    logic          oFrameDone;
    logic [WN:0]   oHitCnt;

    modport master (
        output iStart,
        output iValid,
        output iMag,
        output iTH,
        input  oReady,
        input  TH_addr,
        input  oValid,
        input  oDet,
        input  oBin,
        input  oFrameDone,
        input  oHitCnt
    );

    modport slave (
        input  iStart,
        input  iValid,
        input  iMag,
        input  iTH,
        output oReady,
        output TH_addr,
        output oValid,
        output oDet,
        output oBin,
        output oFrameDone,
        output oHitCnt
    );
endinterface

// File: rtl/bin_threshold_detect.sv
// Per-bin threshold detector for STFT magnitude frames.
//
// Each accepted magnitude is compared (strictly greater, unsigned) against a
// per-bin threshold read from an external ROM. Two-stage pipeline:
//   stage 1 (acceptance edge): capture magnitude, drive ROM address
//   stage 2 (next edge):       compare against iTH, emit result
// so a result appears two rising edges after its acceptance cycle.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   bin_threshold_detect_if.slave (see interface header)
//
// Parameters:
//   WN     bin index width
//   WL     magnitude / threshold width
//   NBINS  bins per frame, 2..2^WN
//
// Optional feature macro: HIT_COUNT_EN
//   defined   -> oHitCnt reports detections of the last completed frame
//   undefined -> oHitCnt tied to 0
module bin_threshold_detect #(
    parameter int WN    = 10,
    parameter int WL    = 10,
    parameter int NBINS = 512
) (
    input  logic clk,
    input  logic rst,
    bin_threshold_detect_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [WN-1:0] LAST_BIN = WN'(NBINS - 1);

    logic [1:0]    state;
    logic [WN-1:0] binCnt;
    logic [WL-1:0] magReg;
    logic          s1Valid;
    logic          accept;
    logic          detNext;
    logic          s1Last;

    // Ready is forced low while reset is held so nothing is taken in.
    assign bus.oReady = (state == RUN) && !rst;
    assign accept     = bus.iValid && bus.oReady;

    // iTH belongs to the address registered on the previous edge.
    assign detNext = magReg > bus.iTH;
    assign s1Last  = s1Valid && (bus.TH_addr == LAST_BIN);

    // Frame control and bin counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            binCnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        state  <= RUN;
                        binCnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // Counter stops at the last bin; no wrap.
                        if (binCnt == LAST_BIN) begin
                            state <= DRAIN;
                        end else begin
                            binCnt <= binCnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Only the last bin is in flight here.
                    if (s1Valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: capture sample, address ROM
    always_ff @(posedge clk) begin
        if (rst) begin
            magReg      <= '0;
            bus.TH_addr <= '0;
            s1Valid     <= 1'b0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                magReg      <= bus.iMag;
                bus.TH_addr <= binCnt;
            end
        end
    end

    // Stage 2: compare and emit
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.oValid     <= 1'b0;
            bus.oDet       <= 1'b0;
            bus.oBin       <= '0;
            bus.oFrameDone <= 1'b0;
        end else begin
            bus.oValid     <= s1Valid;
            bus.oDet       <= s1Valid && detNext;
            bus.oFrameDone <= s1Last;
            if (s1Valid) begin
                bus.oBin <= bus.TH_addr;
            end
        end
    end

`ifdef HIT_COUNT_EN
    logic [WN:0] hitCnt;
    logic        hitNext;

    // Hits are counted as they enter the output register, which is the
    // same set of cycles in which oValid & oDet will be seen.
    assign hitNext = s1Valid && detNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            hitCnt      <= '0;
            bus.oHitCnt <= '0;
        end else begin
            if (state == IDLE && bus.iStart) begin
                hitCnt <= '0;
            end else if (hitNext) begin
                hitCnt <= hitCnt + 1'b1;
            end
            // Final total includes the last bin's own hit.
            if (s1Last) begin
                bus.oHitCnt <= hitCnt + {{WN{1'b0}}, hitNext};
            end
        end
    end
`else
    assign bus.oHitCnt = '0;
`endif

endmodule

// File: tb/tb_bin_threshold_detect.sv
// Randomized self-checking bench for bin_threshold_detect.
// Frame-level reference model predicts every output per cycle.
module tb_bin_threshold_detect;

    localparam int WN    = 10;
    localparam int WL    = 10;
    localparam int NBINS = 8;
    localparam int MAXC  = 8192;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin_threshold_detect_if #(.WN(WN), .WL(WL)) bus ();

    bin_threshold_detect #(
        .WN(WN),
        .WL(WL),
        .NBINS(NBINS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Threshold ROM: data for the current address, valid next cycle
    logic [WL-1:0] rom [NBINS];

    always_comb begin
        bus.iTH = '0;
        if (int'(bus.TH_addr) < NBINS) begin
            bus.iTH = rom[int'(bus.TH_addr)];
        end
    end

    // Reference model state
    int cyc;
    bit expV [MAXC];
    int expB [MAXC];
    bit expD [MAXC];
    bit frameOn;
    bit endSet;
    int startEdge;
    int endEdge;
    int nAcc;
    int hits;
    int lastAddr;
    int binHold;
    int expHit;
    bit pendOn;
    int pendHit;
    int pendEdge;

    int nChecks;
    int nPass;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle, predict, clock, then check.
    task automatic step(input bit s, input bit v, input int mag,
                        input bit r);
        int e;
        bit idle;
        bit rdy;
        bit det;
        int hitExp;
        e = cyc + 1;
        bus.iStart = s;
        bus.iValid = v;
        bus.iMag   = WL'(mag);
        rst        = r;
        if (frameOn && endSet && endEdge < e) frameOn = 1'b0;
        idle = !frameOn;
        rdy  = !r && frameOn && (startEdge < e) && (nAcc < NBINS);
        #1;
        chk("oReady", 32'(bus.oReady), 32'(rdy));
        if (r) begin
            frameOn  = 1'b0;
            endSet   = 1'b0;
            pendOn   = 1'b0;
            nAcc     = 0;
            lastAddr = 0;
            binHold  = 0;
            expHit   = 0;
            for (int k = e; k <= e + 2; k++) expV[k] = 1'b0;
        end else if (idle && s) begin
            frameOn   = 1'b1;
            startEdge = e;
            nAcc      = 0;
            hits      = 0;
            endSet    = 1'b0;
        end else if (rdy && v) begin
            det = mag > int'(rom[nAcc]);
            expV[e+1] = 1'b1;
            expB[e+1] = nAcc;
            expD[e+1] = det;
            hits += int'(det);
            lastAddr = nAcc;
            nAcc++;
            if (nAcc == NBINS) begin
                endSet   = 1'b1;
                endEdge  = e + 1;
                pendOn   = 1'b1;
                pendHit  = hits;
                pendEdge = e + 1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (expV[cyc]) binHold = expB[cyc];
        if (pendOn && pendEdge == cyc) begin
            expHit = pendHit;
            pendOn = 1'b0;
        end
`ifdef HIT_COUNT_EN
        hitExp = expHit;
`else
        hitExp = 0;
`endif
        chk("oValid", 32'(bus.oValid), 32'(expV[cyc]));
        chk("oDet", 32'(bus.oDet), 32'(expV[cyc] && expD[cyc]));
        chk("oBin", 32'(bus.oBin), 32'(binHold));
        chk("oFrameDone", 32'(bus.oFrameDone),
            32'(expV[cyc] && expB[cyc] == NBINS - 1));
        chk("TH_addr", 32'(bus.TH_addr), 32'(lastAddr));
        chk("oHitCnt", 32'(bus.oHitCnt), 32'(hitExp));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    int pat [NBINS];
    int m;

    initial begin
        cyc     = 0;
        nChecks = 0;
        nPass   = 0;
        frameOn = 1'b0;
        endSet  = 1'b0;
        pendOn  = 1'b0;
        nAcc    = 0;
        hits    = 0;
        expHit  = 0;
        binHold = 0;
        lastAddr = 0;
        for (int k = 0; k < MAXC; k++) expV[k] = 1'b0;
        for (int b = 0; b < NBINS; b++) rom[b] = WL'(100);
        bus.iStart = 1'b0;
        bus.iValid = 1'b0;
        bus.iMag   = '0;
        rst        = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        idleCycles(2);

        // Directed frame, all thresholds 100
        pat = '{99, 100, 101, 0, 1023, 100, 200, 50};
        step(1'b1, 1'b0, 0, 1'b0);
        for (int b = 0; b < NBINS; b++) step(1'b0, 1'b1, pat[b], 1'b0);
        idleCycles(4);

        // Valid toggling 1,0,1,0
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 2 * NBINS; i++)
            step(1'b0, (i % 2) == 0, $urandom_range(50, 150), 1'b0);
        idleCycles(4);

        // iStart pulsed mid-frame must not restart
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < NBINS; i++)
            step(i == 3, 1'b1, $urandom_range(0, 1023), 1'b0);
        idleCycles(4);

        // Reset after bin 3, then a fresh frame
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 500, 1'b0);
        step(1'b0, 1'b1, 500, 1'b1);
        step(1'b1, 1'b1, 500, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < NBINS; i++) step(1'b0, 1'b1, 700, 1'b0);
        idleCycles(4);

        // iValid in IDLE without iStart
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1023, 1'b0);

        // Per-bin thresholds bin*10: just above, then equal
        for (int b = 0; b < NBINS; b++) rom[b] = WL'(b * 10);
        step(1'b1, 1'b0, 0, 1'b0);
        for (int b = 0; b < NBINS; b++) step(1'b0, 1'b1, b * 10 + 1, 1'b0);
        idleCycles(3);
        step(1'b1, 1'b0, 0, 1'b0);
        for (int b = 0; b < NBINS; b++) step(1'b0, 1'b1, b * 10, 1'b0);
        idleCycles(3);

        // Random frames, random ROM, gaps and stray iStart
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < NBINS; b++)
                rom[b] = WL'($urandom_range(0, 1023));
            step(1'b1, 1'b0, 0, 1'b0);
            for (int i = 0; i < 100 && frameOn; i++) begin
                if (($urandom % 4) == 0 && nAcc < NBINS)
                    m = int'(rom[nAcc]);
                else
                    m = $urandom_range(0, 1023);
                step(($urandom % 8) == 0, ($urandom % 3) != 0, m, 1'b0);
            end
            idleCycles(3);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/bin_threshold_detect.md
BIN_THRESHOLD_DETECT -- requirements
Module: bin_threshold_detect

Interface
REQ-001 Parameter WN, default 10, threshold-ROM address width (bin index width).
REQ-002 Parameter WL, default 10, magnitude and threshold width.
REQ-003 Parameter NBINS, default 512, bins per frame; legal range 2..2^WN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 iStart  input  1  one-cycle frame start request.
REQ-007 iValid  input  1  magnitude sample valid.
REQ-008 oReady  output  1  block accepts a sample this cycle.
REQ-009 iMag  input  WL  unsigned STFT bin magnitude.
REQ-010 TH_addr  output  WN  threshold ROM address (bin index).
REQ-011 iTH  input  WL  threshold word returned by the ROM for TH_addr, valid in the cycle after TH_addr changes.
REQ-012 oValid  output  1  detection result valid.
REQ-013 oDet  output  1  1 = magnitude strictly above threshold.
REQ-014 oBin  output  WN  bin index of the current result.
REQ-015 oFrameDone  output  1  one-cycle pulse with the result of bin NBINS-1.
REQ-016 oHitCnt  output  WN+1  detections in the last completed frame (HIT_COUNT_EN only).

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on iStart.
- RUN -> DRAIN when bin NBINS-1 is accepted.
- DRAIN -> IDLE when the last result is emitted.
REQ-018 oReady = 1 only in RUN; a sample is accepted when iValid and oReady are both 1; iValid outside RUN is ignored.
REQ-019 iStart is ignored in RUN and DRAIN; no frame restart mid-frame.
REQ-020 Bin counter: cleared to 0 on IDLE->RUN; increments per accepted sample; never exceeds NBINS-1; no wrap within a frame.
REQ-021 Stage 1, on acceptance:
- register iMag into a magnitude pipeline register;
- register the bin index into TH_addr.
REQ-022 Stage 2, one cycle after acceptance:
- oDet = (registered magnitude > iTH), unsigned compare, equal gives 0;
- oBin = TH_addr;
- oValid = 1.
REQ-023 Latency: an accepted sample's result appears exactly 2 rising edges after acceptance; back-to-back samples give back-to-back results at one per cycle.
REQ-024 Gaps in iValid during RUN insert matching gaps in oValid; order is preserved.
REQ-025 TH_addr holds its last value when no sample is accepted.
REQ-026 When oValid = 0, oDet is 0; oBin holds its last value.
REQ-027 oFrameDone = 1 exactly in the cycle oValid = 1 with oBin = NBINS-1.

Reset
REQ-028 rst asserted in any state, including mid-frame, forces on the next edge:
- state IDLE, bin counter 0, TH_addr 0;
- oValid 0, oDet 0, oBin 0, oFrameDone 0, oHitCnt 0;
- in-flight samples discarded, with no partial frame result.
REQ-029 During rst, oReady = 0 and iStart is ignored.

Configuration
REQ-030 Macro HIT_COUNT_EN.
- Defined: an internal counter of WN+1 bits clears on IDLE->RUN and increments when oValid & oDet; oHitCnt is loaded with the final count on the edge where oFrameDone is asserted, including that bin's hit, and holds until the next frame completes.
- Not defined: no counter logic; oHitCnt is tied to 0.

Verification
REQ-031 NBINS=8, iTH=100 for all bins, iMag = 99,100,101,0,1023,100,200,50 contiguous after iStart -> oDet = 0,0,1,0,1,0,1,0; oValid for 8 consecutive cycles starting 2 edges after the first acceptance; oFrameDone on bin 7; oHitCnt=3 (HIT_COUNT_EN).
REQ-032 iValid toggling 1,0,1,0 during RUN -> results interleaved with idle cycles; oBin increments only on valid results; latency stays at 2.
REQ-033 iValid=1 and iStart pulsed during RUN -> no counter restart; the frame completes with NBINS results.
REQ-034 rst asserted after bin 3 of 8 -> next cycle all outputs at reset values; a new iStart frame starts at bin 0 with oHitCnt = 0 before it completes.
REQ-035 iValid=1 in IDLE without iStart -> oReady = 0, no oValid, TH_addr unchanged.
REQ-036 Per-bin iTH = bin*10 from a ROM model, iMag = bin*10 + 1 -> all oDet = 1; iMag = bin*10 -> all oDet = 0.
